// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: op codes and op-code legality.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;

  // True for the four op codes the datapath implements.
  function automatic logic is_valid_op(input alu_op_t op);
    logic v;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: v = 1'b1;
      default:                           v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or after the
// pointer, then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] eligible,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] r_ptr;
  logic          w_found;
  int            w_idx;

  // Search from the pointer upward with wrap; no grant while in reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && !rst && eligible[w_idx]) begin
        w_found         = 1'b1;
        grant[w_idx]    = 1'b1;
        grant_idx       = IW'(w_idx);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Pointer advances past the granted index; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (|grant) begin
      if (grant_idx == IW'(NREQ - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= grant_idx + IW'(1);
      end
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters. Requests are
// round-robin arbitrated; each requester owns a one-entry result slot that
// is written one cycle after acceptance and held until consumed.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0][3:0]    req_op,
  input  logic [NREQ-1:0][W-1:0]  req_a,
  input  logic [NREQ-1:0][W-1:0]  req_b,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [NREQ-1:0][W-1:0]  rsp_data,
  output logic [NREQ-1:0]         rsp_zero,
  output logic [NREQ-1:0]         rsp_err,
  output logic                    busy
);

  logic [NREQ-1:0]        r_rsp_valid;
  logic [NREQ-1:0][W-1:0] r_rsp_data;
  logic [NREQ-1:0]        r_rsp_zero;
  logic [NREQ-1:0]        r_rsp_err;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  alu_op_t         w_op;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [W-1:0]    w_res;
  logic            w_zero;
  logic            w_err;

  // A requester may issue when its slot is empty or draining this cycle;
  // this uses only handshake state, never the operands.
  always_comb begin
    w_elig = req_valid & (~r_rsp_valid | rsp_ready);
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .eligible  (w_elig),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  // Steer the granted requester's op and operands into the datapath.
  always_comb begin
    w_op = req_op[w_gidx];
    w_a  = req_a[w_gidx];
    w_b  = req_b[w_gidx];
  end

  // ALU datapath: modulo add/sub, undefined ops give zero data and err.
  always_comb begin
    case (w_op)
      ALU_AND: w_res = w_a & w_b;
      ALU_OR:  w_res = w_a | w_b;
      ALU_ADD: w_res = w_a + w_b;
      ALU_SUB: w_res = w_a - w_b;
      default: w_res = '0;
    endcase
    w_err  = ~is_valid_op(w_op);
    w_zero = (w_res == '0);
  end

  // Result slots: capture on grant, clear valid on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= '0;
      r_rsp_err   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_grant[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_data[i]  <= w_res;
          r_rsp_zero[i]  <= w_zero;
          r_rsp_err[i]   <= w_err;
        end else if (r_rsp_valid[i] && rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end else begin
          r_rsp_valid[i] <= r_rsp_valid[i];
        end
      end
    end
  end

  // Handshake and status outputs; busy is forced low during reset.
  always_comb begin
    req_ready = w_grant;
    rsp_valid = r_rsp_valid;
    rsp_data  = r_rsp_data;
    rsp_zero  = r_rsp_zero;
    rsp_err   = r_rsp_err;
    busy      = ~rst & ((|r_rsp_valid) | (|w_grant));
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (NREQ=2, W=32) with hand-computed
// expected values.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][3:0]   req_op;
  logic [NREQ-1:0][W-1:0] req_a;
  logic [NREQ-1:0][W-1:0] req_b;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [NREQ-1:0][W-1:0] rsp_data;
  logic [NREQ-1:0]        rsp_zero;
  logic [NREQ-1:0]        rsp_err;
  logic                   busy;

  int n_checks;
  int n_fail;

  alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b00;
    step();
    step();

    // Reset state
    req_valid = 2'b01;
    settle();
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_data0", 64'(rsp_data[0]), 64'h0);

    // Reset mid-operation: req0 ADD 5+7 accepted, then reset
    rst       = 1'b0;
    req_op[0] = ALU_ADD;
    req_a[0]  = 32'd5;
    req_b[0]  = 32'd7;
    settle();
    check("midrst_grant", 64'(req_ready), 64'h1);
    step();
    rst       = 1'b1;
    req_valid = 2'b00;
    settle();
    check("midrst_busy_in_rst", 64'(busy), 64'h0);
    step();
    rst = 1'b0;
    settle();
    check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("midrst_no_stale", 64'(rsp_data[0]), 64'h0);
    req_valid = 2'b11;
    settle();
    check("midrst_ptr0", 64'(req_ready), 64'h1);

    // Single requester: 0xFFFFFFFF + 1 wraps to 0
    req_valid = 2'b01;
    req_op[0] = ALU_ADD;
    req_a[0]  = 32'hFFFF_FFFF;
    req_b[0]  = 32'h1;
    settle();
    check("single_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    settle();
    check("single_valid", 64'(rsp_valid), 64'h1);
    check("single_data", 64'(rsp_data[0]), 64'h0);
    check("single_zero", 64'(rsp_zero[0]), 64'h1);
    check("single_err", 64'(rsp_err[0]), 64'h0);
    rsp_ready = 2'b01;
    step();
    check("single_drained", 64'(rsp_valid), 64'h0);
    check("single_data_kept", 64'(rsp_data[0]), 64'h0);

    // Contention: pointer is 1 after the grant to req0, so 10,01,10,01
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_op[0] = ALU_SUB;
    req_a[0]  = 32'd10;
    req_b[0]  = 32'd3;
    req_op[1] = ALU_AND;
    req_a[1]  = 32'h0000_F0F0;
    req_b[1]  = 32'h0000_FF00;
    for (int c = 0; c < 4; c++) begin
      logic [1:0] exp_g;
      exp_g = (c % 2 == 0) ? 2'b10 : 2'b01;
      settle();
      check($sformatf("cont_grant%0d", c), 64'(req_ready), 64'(exp_g));
      check($sformatf("cont_busy%0d", c), 64'(busy), 64'h1);
      step();
      check($sformatf("cont_valid%0d", c), 64'(rsp_valid), 64'(exp_g));
      if (exp_g[0]) check($sformatf("cont_sub%0d", c), 64'(rsp_data[0]), 64'd7);
      else          check($sformatf("cont_and%0d", c), 64'(rsp_data[1]), 64'hF000);
    end

    // Backpressure: slot0 holds 7, not consumed; req1 gets the ALU
    rsp_ready = 2'b00;
    settle();
    check("bp_ready_req1", 64'(req_ready), 64'h2);
    step();
    check("bp_valid_both", 64'(rsp_valid), 64'h3);
    check("bp_none_eligible", 64'(req_ready), 64'h0);
    check("bp_hold0", 64'(rsp_data[0]), 64'd7);
    step();
    check("bp_still_hold0", 64'(rsp_data[0]), 64'd7);
    rsp_ready = 2'b01;
    req_op[0] = ALU_ADD;
    req_a[0]  = 32'd20;
    req_b[0]  = 32'd22;
    settle();
    check("bp_same_cycle_ready", 64'(req_ready), 64'h1);
    step();
    check("bp_refill_valid", 64'(rsp_valid), 64'h3);
    check("bp_refill_data", 64'(rsp_data[0]), 64'd42);

    // Drain everything; pointer is now 1
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step();
    check("drain_all", 64'(rsp_valid), 64'h0);
    check("idle_busy", 64'(busy), 64'h0);

    // Illegal op on req1
    rsp_ready = 2'b00;
    req_valid = 2'b10;
    req_op[1] = 4'b1111;
    req_a[1]  = 32'd3;
    req_b[1]  = 32'd4;
    settle();
    check("ill_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 2'b00;
    settle();
    check("ill_valid", 64'(rsp_valid), 64'h2);
    check("ill_data", 64'(rsp_data[1]), 64'h0);
    check("ill_zero", 64'(rsp_zero[1]), 64'h1);
    check("ill_err", 64'(rsp_err[1]), 64'h1);
    rsp_ready = 2'b10;
    step();

    // Back-to-back on req0: ADD i + 2i, one result per cycle
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    req_op[0] = ALU_ADD;
    for (int i = 1; i <= 4; i++) begin
      req_a[0] = 32'(i);
      req_b[0] = 32'(2 * i);
      settle();
      check($sformatf("b2b_ready%0d", i), 64'(req_ready), 64'h1);
      step();
      check($sformatf("b2b_valid%0d", i), 64'(rsp_valid[0]), 64'h1);
      check($sformatf("b2b_data%0d", i), 64'(rsp_data[0]), 64'(3 * i));
      check($sformatf("b2b_zero%0d", i), 64'(rsp_zero[0]), 64'h0);
    end

    // OR, then SUB with borrow wrap, still back-to-back
    req_op[0] = ALU_OR;
    req_a[0]  = 32'h0000_00A0;
    req_b[0]  = 32'h0000_0005;
    step();
    check("or_data", 64'(rsp_data[0]), 64'hA5);
    check("or_err", 64'(rsp_err[0]), 64'h0);
    req_op[0] = ALU_SUB;
    req_a[0]  = 32'd3;
    req_b[0]  = 32'd5;
    step();
    check("sub_wrap", 64'(rsp_data[0]), 64'hFFFF_FFFE);
    check("sub_valid", 64'(rsp_valid), 64'h1);
    req_valid = 2'b00;
    step();
    check("final_drain", 64'(rsp_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
